mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 33 +++
 rtl/mem_arb_select.sv | 36 +++
 rtl/mem_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM states, requester IDs, grant bit positions.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    ID_NONE = 2'd0,
    ID_IF   = 2'd1,
    ID_LSB  = 2'd2,
    ID_PF   = 2'd3
  } req_id_e;

  // IF and PF always fetch a full 32-bit word (len is bytes-1).
  localparam logic [1:0] LEN_WORD = 2'd3;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_IF  = 0;
  localparam int GNT_LSB = 1;
  localparam int GNT_PF  = 2;
  localparam int GNT_W   = 3;

  function automatic req_id_e gnt_to_id(input logic [GNT_W-1:0] gnt);
    if (gnt[GNT_LSB]) return ID_LSB;
    if (gnt[GNT_IF])  return ID_IF;
    if (gnt[GNT_PF])  return ID_PF;
    return ID_NONE;
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational priority selector: LSB > IF > PF, except a starved IF request wins outright.
// The PF input exists only when MEM_ARB_PF_EN is defined.
module mem_arb_select
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                                  if_req,
  input  logic                                  lsb_req,
`ifdef MEM_ARB_PF_EN
  input  logic                                  pf_req,
`endif
  input  logic [$clog2(STARVE_LIMIT + 1)-1:0]   ifwait_cnt,
  output logic [GNT_W-1:0]                      gnt
);

  // STARVE_LIMIT must be at least 1 so the counter has a non-zero width.
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  always_comb begin
    gnt = '0;
    if (if_req && (ifwait_cnt >= LIMIT)) begin
      gnt[GNT_IF] = 1'b1;
    end else if (lsb_req) begin
      gnt[GNT_LSB] = 1'b1;
    end else if (if_req) begin
      gnt[GNT_IF] = 1'b1;
`ifdef MEM_ARB_PF_EN
    end else if (pf_req) begin
      gnt[GNT_PF] = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding memory arbiter between instruction fetch, load/store buffer and prefetch.
// Prefetch participates only when MEM_ARB_PF_EN is defined; otherwise the PF port is inert.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clr_in,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,

  input  logic        lsb_req,
  input  logic        lsb_wr,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_addr,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_done,
  output logic [31:0] lsb_rdata,

  input  logic        pf_req,
  input  logic [31:0] pf_addr,
  output logic        pf_done,
  output logic [31:0] pf_data,

  output logic        arb_to_mc_ready,
  output logic        arb_to_mc_wr,
  output logic [1:0]  arb_to_mc_len,
  output logic [31:0] arb_to_mc_addr,
  output logic [31:0] arb_to_mc_data,

  input  logic        mc_to_arb_done,
  input  logic [31:0] mc_to_arb_data
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  req_id_e          gnt_id_q, gnt_id_d;
  logic [CNT_W-1:0] ifwait_q, ifwait_d;
  logic             ready_q, ready_d;
  logic             mc_wr_q, mc_wr_d;
  logic [1:0]       mc_len_q, mc_len_d;
  logic [31:0]      mc_addr_q, mc_addr_d;
  logic [31:0]      mc_data_q, mc_data_d;
  logic             if_done_q, if_done_d;
  logic [31:0]      if_data_q, if_data_d;
  logic             lsb_done_q, lsb_done_d;
  logic [31:0]      lsb_rdata_q, lsb_rdata_d;
`ifdef MEM_ARB_PF_EN
  logic             pf_done_q, pf_done_d;
  logic [31:0]      pf_data_q, pf_data_d;
`endif

  logic [GNT_W-1:0] gnt;
  logic             mc_accept;
  logic             is_store;

  mem_arb_select #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_select (
    .if_req     (if_req),
    .lsb_req    (lsb_req),
`ifdef MEM_ARB_PF_EN
    .pf_req     (pf_req),
`endif
    .ifwait_cnt (ifwait_q),
    .gnt        (gnt)
  );

  // A done arriving while the ready pulse is still pending cannot belong to this
  // request; ignoring it also enforces the three-cycle grant-to-grant spacing.
  assign mc_accept = mc_to_arb_done && !ready_q;
  assign is_store  = (gnt_id_q == ID_LSB) && mc_wr_q;

  always_comb begin
    state_d     = state_q;
    gnt_id_d    = gnt_id_q;
    ifwait_d    = ifwait_q;
    ready_d     = ready_q;
    mc_wr_d     = mc_wr_q;
    mc_len_d    = mc_len_q;
    mc_addr_d   = mc_addr_q;
    mc_data_d   = mc_data_q;
    if_done_d   = if_done_q;
    if_data_d   = if_data_q;
    lsb_done_d  = lsb_done_q;
    lsb_rdata_d = lsb_rdata_q;
`ifdef MEM_ARB_PF_EN
    pf_done_d   = pf_done_q;
    pf_data_d   = pf_data_q;
`endif

    // With rdy_in low everything holds, so pending pulses survive the pause.
    if (rdy_in) begin
      ready_d    = 1'b0;
      if_done_d  = 1'b0;
      lsb_done_d = 1'b0;
`ifdef MEM_ARB_PF_EN
      pf_done_d  = 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (!clr_in && (|gnt)) begin
            state_d  = ST_WAIT;
            ready_d  = 1'b1;
            gnt_id_d = gnt_to_id(gnt);
            if (gnt[GNT_LSB]) begin
              mc_wr_d   = lsb_wr;
              mc_len_d  = lsb_len;
              mc_addr_d = lsb_addr;
              mc_data_d = lsb_wdata;
            end else begin
              mc_wr_d   = 1'b0;
              mc_len_d  = LEN_WORD;
              mc_data_d = '0;
`ifdef MEM_ARB_PF_EN
              mc_addr_d = gnt[GNT_PF] ? pf_addr : if_addr;
`else
              mc_addr_d = if_addr;
`endif
            end
            if (gnt[GNT_IF]) begin
              ifwait_d = '0;
            end else if (if_req && (ifwait_q != LIMIT)) begin
              ifwait_d = ifwait_q + CNT_W'(1);
            end
          end
        end

        ST_WAIT: begin
          // Stores are architecturally committed, so a flush never cancels them.
          if (clr_in && !is_store) begin
            state_d = mc_accept ? ST_IDLE : ST_DRAIN;
          end else if (mc_accept) begin
            state_d = ST_IDLE;
            case (gnt_id_q)
              ID_IF: begin
                if_data_d = mc_to_arb_data;
                if_done_d = 1'b1;
              end
              ID_LSB: begin
                lsb_rdata_d = mc_to_arb_data;
                lsb_done_d  = 1'b1;
              end
`ifdef MEM_ARB_PF_EN
              ID_PF: begin
                pf_data_d = mc_to_arb_data;
                pf_done_d = 1'b1;
              end
`endif
              default: ;
            endcase
          end
        end

        ST_DRAIN: begin
          if (mc_accept) begin
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      gnt_id_q    <= ID_NONE;
      ifwait_q    <= '0;
      ready_q     <= 1'b0;
      mc_wr_q     <= 1'b0;
      mc_len_q    <= '0;
      mc_addr_q   <= '0;
      mc_data_q   <= '0;
      if_done_q   <= 1'b0;
      if_data_q   <= '0;
      lsb_done_q  <= 1'b0;
      lsb_rdata_q <= '0;
`ifdef MEM_ARB_PF_EN
      pf_done_q   <= 1'b0;
      pf_data_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_id_q    <= gnt_id_d;
      ifwait_q    <= ifwait_d;
      ready_q     <= ready_d;
      mc_wr_q     <= mc_wr_d;
      mc_len_q    <= mc_len_d;
      mc_addr_q   <= mc_addr_d;
      mc_data_q   <= mc_data_d;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
      lsb_done_q  <= lsb_done_d;
      lsb_rdata_q <= lsb_rdata_d;
`ifdef MEM_ARB_PF_EN
      pf_done_q   <= pf_done_d;
      pf_data_q   <= pf_data_d;
`endif
    end
  end

  // Pulses are masked, not cleared, during a pause so each one is seen exactly once.
  assign arb_to_mc_ready = ready_q & rdy_in;
  assign arb_to_mc_wr    = mc_wr_q;
  assign arb_to_mc_len   = mc_len_q;
  assign arb_to_mc_addr  = mc_addr_q;
  assign arb_to_mc_data  = mc_data_q;
  assign if_done         = if_done_q & rdy_in;
  assign if_data         = if_data_q;
  assign lsb_done        = lsb_done_q & rdy_in;
  assign lsb_rdata       = lsb_rdata_q;

`ifdef MEM_ARB_PF_EN
  assign pf_done = pf_done_q & rdy_in;
  assign pf_data = pf_data_q;
`else
  logic unused_pf;
  assign unused_pf = ^{pf_req, pf_addr};
  assign pf_done   = 1'b0;
  assign pf_data   = '0;
`endif

endmodule
